// File: rtl/data_sampling_nx.sv
// Oversampling majority-vote bit sampler for a UART receiver, with input synchroniser and abort handling.
// Optional noise flag is compiled in when DATA_SAMPLING_NOISE_DET_EN is defined.
module data_sampling_nx #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescaler,
    input  logic                  Data_Sample_EN,
    input  logic [PRESCALE_W-1:0] Edge_Counter,
    output logic                  Sampled_bit,
    output logic                  Sampling_done,
    output logic                  Noise_err
);

    localparam int EXT_W = PRESCALE_W + 1;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [EXT_W-1:0] HALF       = EXT_W'(NUM_SAMPLES / 2);
    localparam logic [EXT_W-1:0] MIN_NORMAL = EXT_W'(2 * (NUM_SAMPLES / 2) + 2);
    localparam logic [CNT_W-1:0] WIN        = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] MAJ        = CNT_W'(NUM_SAMPLES / 2);

    generate
        if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
            $error("data_sampling_nx: NUM_SAMPLES must be 1, 3, 5 or 7");
        end
        if (SYNC_STAGES < 0) begin : g_bad_sync_stages
            $error("data_sampling_nx: SYNC_STAGES must be >= 0");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchroniser: flops preset to the idle-high line level
    // ------------------------------------------------------------------
    logic rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign rx_s = RX_IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= RX_IN;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window arithmetic, one bit wider than the counter so nothing wraps
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] presc_ext;
    logic [EXT_W-1:0] ec_ext;
    logic [EXT_W-1:0] mid;
    logic [EXT_W-1:0] start;
    logic             normal_mode;
    logic             single_sample;

    assign presc_ext   = {1'b0, prescaler};
    assign ec_ext      = {1'b0, Edge_Counter};
    assign mid         = presc_ext >> 1;
    assign normal_mode = (presc_ext >= MIN_NORMAL);
    assign start       = normal_mode ? (mid - HALF) : mid;
    // A one-wide window votes on the very capture that opens it
    assign single_sample = !normal_mode || (NUM_SAMPLES == 1);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] idx_q;
    logic             bit_q;
    logic             done_q;
    logic             noise_q;

    logic [CNT_W-1:0] ones_d;
    logic [CNT_W-1:0] idx_d;
    logic             capture_hit;
    logic             collect_abort;

    assign ones_d        = ones_q + CNT_W'(rx_s);
    assign idx_d         = idx_q + CNT_W'(1);
    assign capture_hit   = Data_Sample_EN && (ec_ext == (start + EXT_W'(idx_q)));
    assign collect_abort = !Data_Sample_EN || (Edge_Counter == '0);

`ifdef DATA_SAMPLING_NOISE_DET_EN
    logic [CNT_W-1:0] zeros_q;
    logic [CNT_W-1:0] zeros_d;

    assign zeros_d = zeros_q + CNT_W'(!rx_s);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ones_q  <= '0;
            idx_q   <= '0;
            bit_q   <= 1'b1;
            done_q  <= 1'b0;
            noise_q <= 1'b0;
`ifdef DATA_SAMPLING_NOISE_DET_EN
            zeros_q <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            noise_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (capture_hit) begin
                        ones_q <= ones_d;
                        idx_q  <= idx_d;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                        zeros_q <= zeros_d;
`endif
                        if (single_sample) begin
                            bit_q   <= rx_s;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    // Start is never 0 in a multi-sample window, so count 0 here is always an abort
                    if (collect_abort) begin
                        ones_q  <= '0;
                        idx_q   <= '0;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                        zeros_q <= '0;
`endif
                        state_q <= S_IDLE;
                    end else if (capture_hit) begin
                        ones_q <= ones_d;
                        idx_q  <= idx_d;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                        zeros_q <= zeros_d;
`endif
                        if (idx_d == WIN) begin
                            bit_q   <= (ones_d > MAJ);
                            done_q  <= 1'b1;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                            noise_q <= (ones_d != '0) && (zeros_d != '0);
`endif
                            state_q <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (collect_abort) begin
                        ones_q  <= '0;
                        idx_q   <= '0;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                        zeros_q <= '0;
`endif
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    ones_q  <= '0;
                    idx_q   <= '0;
`ifdef DATA_SAMPLING_NOISE_DET_EN
                    zeros_q <= '0;
`endif
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Sampled_bit   = bit_q;
    assign Sampling_done = done_q;
`ifdef DATA_SAMPLING_NOISE_DET_EN
    assign Noise_err = noise_q;
`else
    assign Noise_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sampling_nx.sv
// Directed bench for data_sampling_nx: three configurations share one stimulus stream and are checked
// every cycle against a window/majority model, plus literal expectations for the key scenarios.
module tb_data_sampling_nx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       en    = 1'b0;
    logic [5:0] presc = 6'd8;
    logic [5:0] ec    = 6'd0;
    logic [2:0] bit_v;
    logic [2:0] done_v;
    logic [2:0] noise_v;

    int n_vec = 0;
    int n_err = 0;

`ifdef DATA_SAMPLING_NOISE_DET_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    // a: 3 samples, no sync; b: 5 samples, 2 sync flops; c: 3 samples, 2 sync flops
    data_sampling_nx #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(0)) dut_a (
        .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .prescaler(presc), .Data_Sample_EN(en),
        .Edge_Counter(ec), .Sampled_bit(bit_v[0]), .Sampling_done(done_v[0]), .Noise_err(noise_v[0]));
    data_sampling_nx #(.PRESCALE_W(6), .NUM_SAMPLES(5), .SYNC_STAGES(2)) dut_b (
        .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .prescaler(presc), .Data_Sample_EN(en),
        .Edge_Counter(ec), .Sampled_bit(bit_v[1]), .Sampling_done(done_v[1]), .Noise_err(noise_v[1]));
    data_sampling_nx #(.PRESCALE_W(6), .NUM_SAMPLES(3), .SYNC_STAGES(2)) dut_c (
        .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .prescaler(presc), .Data_Sample_EN(en),
        .Edge_Counter(ec), .Sampled_bit(bit_v[2]), .Sampling_done(done_v[2]), .Noise_err(noise_v[2]));

    // ------------------------------------------------------------------
    // Model: rx history per configuration, sample list length and ones count per bit period
    // ------------------------------------------------------------------
    bit m_bit   [3];
    bit m_done  [3];
    bit m_noise [3];
    int m_cnt   [3];
    int m_ones  [3];
    bit m_voted [3];
    bit hist    [3][2];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_bit[d] = 1'b1; m_done[d] = 1'b0; m_noise[d] = 1'b0;
            m_cnt[d] = 0; m_ones[d] = 0; m_voted[d] = 1'b0;
            hist[d][0] = 1'b1; hist[d][1] = 1'b1;
        end
    endfunction

    function automatic void model_step(input int d);
        int n, s, p, mid, half, start, wsz;
        bit rxs, normal;
        n = (d == 1) ? 5 : 3;
        s = (d == 0) ? 0 : 2;
        rxs = (s == 0) ? rx_in : hist[d][1];
        hist[d][1] = hist[d][0];
        hist[d][0] = rx_in;
        p      = int'(presc);
        mid    = p / 2;
        half   = n / 2;
        normal = (p >= 2 * half + 2);
        start  = normal ? mid - half : mid;
        wsz    = normal ? n : 1;
        m_done[d]  = 1'b0;
        m_noise[d] = 1'b0;
        if (!en || ec == 6'd0) begin
            m_cnt[d] = 0; m_ones[d] = 0; m_voted[d] = 1'b0;
        end
        if (en && !m_voted[d] && int'(ec) == start + m_cnt[d]) begin
            m_cnt[d]  = m_cnt[d] + 1;
            m_ones[d] = m_ones[d] + int'(rxs);
            if (m_cnt[d] == wsz) begin
                m_bit[d]   = (m_ones[d] * 2 > wsz);
                m_done[d]  = 1'b1;
                m_noise[d] = NOISE_ON && (m_ones[d] != 0) && (m_ones[d] != wsz);
                m_voted[d] = 1'b1;
                m_cnt[d] = 0; m_ones[d] = 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int d = 0; d < 3; d++) model_step(d);
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    function automatic void chk(input string name, input int d, input logic act, input bit exp);
        n_vec++;
        if (act !== logic'(exp)) begin
            n_err++;
            $display("FAIL %s dut%0d: got %b, expected %b (t=%0t ec=%0d)", name, d, act, exp, $time, ec);
        end
    endfunction

    function automatic void lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    int dcnt [3];
    int dec  [3];
    int nseen[3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            chk("sampled_bit", d, bit_v[d], m_bit[d]);
            chk("sampling_done", d, done_v[d], m_done[d]);
            chk("noise_err", d, noise_v[d], m_noise[d]);
            if (done_v[d] === 1'b1) begin
                dcnt[d]++;
                dec[d] = int'(ec);
                if (noise_v[d] === 1'b1) nseen[d] = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clear_stats();
        for (int d = 0; d < 3; d++) begin
            dcnt[d] = 0; dec[d] = -1; nseen[d] = 0;
        end
    endtask

    // One bit period: rxv[c] is RX_IN at count c; enable drops from count drop_at (<0: never)
    task automatic run_bit(input int p, input logic [63:0] rxv, input int drop_at);
        clear_stats();
        presc = 6'(p);
        for (int c = 0; c < p; c++) begin
            ec    = 6'(c);
            en    = (drop_at < 0) || (c < drop_at);
            rx_in = rxv[c];
            @(posedge clk); #1;
        end
        ec = 6'd0; en = 1'b1; rx_in = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        lit("reset_bit_a", int'(bit_v[0]), 1);
        lit("reset_done_a", int'(done_v[0]), 0);
        lit("reset_bit_b", int'(bit_v[1]), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zeros at counts 3..5, 3 samples at prescaler 8
        run_bit(8, ~64'h38, -1);
        $display("vec t1 p=8 zeros@3..5: a bit=%b done_cnt=%0d done_ec=%0d", bit_v[0], dcnt[0], dec[0]);
        lit("t1_bit_a", int'(bit_v[0]), 0);
        lit("t1_done_cnt_a", dcnt[0], 1);
        lit("t1_done_ec_a", dec[0], 6);
        lit("t1_noise_a", nseen[0], 0);

        // 5 samples at prescaler 16: rx_s 1,0,1,1,0 over counts 6..10 (pin pattern two clocks earlier)
        run_bit(16, ~64'h120, -1);
        $display("vec t2 p=16 pattern 10110: b bit=%b done_cnt=%0d noise=%0d", bit_v[1], dcnt[1], nseen[1]);
        lit("t2_bit_b", int'(bit_v[1]), 1);
        lit("t2_done_cnt_b", dcnt[1], 1);
        lit("t2_done_ec_b", dec[1], 11);
        lit("t2_noise_b", nseen[1], int'(NOISE_ON));
        lit("t2_bit_a", int'(bit_v[0]), 1);

        // Single-sample mode at prescaler 2
        run_bit(2, ~64'h2, -1);
        $display("vec t3a p=2 rx@1=0: a bit=%b done_ec=%0d", bit_v[0], dec[0]);
        lit("t3_bit_a_zero", int'(bit_v[0]), 0);
        lit("t3_done_ec_a", dec[0], 0);
        lit("t3_done_cnt_a", dcnt[0], 1);
        run_bit(2, '1, -1);
        $display("vec t3b p=2 rx@1=1: a bit=%b", bit_v[0]);
        lit("t3_bit_a_one", int'(bit_v[0]), 1);
        lit("t3_noise_a", nseen[0], 0);

        // Abort: enable drops at count 4 after one capture; prior value held, next bit clean
        run_bit(8, '0, -1);
        $display("vec t4a p=8 all zero: a bit=%b", bit_v[0]);
        lit("t4_prior_bit_a", int'(bit_v[0]), 0);
        run_bit(8, '1, 4);
        $display("vec t4b p=8 abort@4: a bit=%b done_cnt=%0d", bit_v[0], dcnt[0]);
        lit("t4_abort_done_cnt_a", dcnt[0], 0);
        lit("t4_abort_bit_a", int'(bit_v[0]), 0);
        run_bit(8, '1, -1);
        $display("vec t4c p=8 all one: a bit=%b done_ec=%0d", bit_v[0], dec[0]);
        lit("t4_next_bit_a", int'(bit_v[0]), 1);
        lit("t4_next_done_ec_a", dec[0], 6);

        // Two sync flops: pin goes low at count 1 so rx_s is 0 over counts 3..5
        run_bit(8, 64'h1, -1);
        $display("vec t5 p=8 sync2 step: c bit=%b done_ec=%0d", bit_v[2], dec[2]);
        lit("t5_bit_c", int'(bit_v[2]), 0);
        lit("t5_done_cnt_c", dcnt[2], 1);
        lit("t5_done_ec_c", dec[2], 6);

        // Reset asserted mid-window (dut_a in COLLECT at count 4)
        clear_stats();
        presc = 6'd8;
        for (int c = 0; c <= 4; c++) begin
            ec = 6'(c); en = 1'b1; rx_in = 1'b0;
            if (c < 4) begin
                @(posedge clk); #1;
            end
        end
        lit("t6_prior_bit_a", int'(bit_v[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        $display("vec t6 reset in collect: a bit=%b done=%b", bit_v[0], done_v[0]);
        lit("t6_async_bit_a", int'(bit_v[0]), 1);
        lit("t6_async_done_a", int'(done_v[0]), 0);
        ec = 6'd0; en = 1'b0; rx_in = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        lit("t6_done_during_reset_a", dcnt[0], 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_bit(8, '0, -1);
        $display("vec t6b after reset p=8 all zero: a bit=%b done_cnt=%0d", bit_v[0], dcnt[0]);
        lit("t6_after_bit_a", int'(bit_v[0]), 0);
        lit("t6_after_done_cnt_a", dcnt[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_sampling_nx.md
Name: data_sampling_nx

Overview:
- Parametrised successor to the UART RX 3-sample majority sampler.
- Takes a configurable odd number of oversamples, centred on the mid-bit edge count, and registers a majority vote.
- Adds an input synchroniser, a small control FSM and clean abort handling.
- Sits between the RX edge/bit counter and the deserializer/parity/stop checkers.

Parameters:
- PRESCALE_W, 6, width of prescaler and Edge_Counter; supports prescaler up to 2^PRESCALE_W-1.
- NUM_SAMPLES, 3, odd number of samples per bit; legal values 1, 3, 5, 7.
- SYNC_STAGES, 2, flops on RX_IN before sampling; 0 means RX_IN is used directly.

Ports:
- CLK  in  1  sampling clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- RX_IN  in  1  serial line, idle high.
- prescaler  in  PRESCALE_W  oversampling ratio (clocks per bit); static while Data_Sample_EN=1.
- Data_Sample_EN  in  1  enables sampling for the current bit.
- Edge_Counter  in  PRESCALE_W  clock index within the current bit, 0..prescaler-1.
- Sampled_bit  out  1  registered majority result; holds until the next vote.
- Sampling_done  out  1  one-cycle pulse when Sampled_bit updates.
- Noise_err  out  1  one-cycle pulse with Sampling_done when samples disagree (see Optional Feature).

Behaviour:
- Reset (RST=0, async): Sampled_bit=1, Sampling_done=0, Noise_err=0, synchroniser flops=1, FSM=IDLE, ones/index counters=0.
- Sampling input rx_s is RX_IN delayed by SYNC_STAGES clocks. The upstream counter absorbs this fixed delay; this block does not compensate.
- Window arithmetic (PRESCALE_W+1 bits, no wrap):
  - mid = prescaler>>1; half = NUM_SAMPLES>>1.
  - Normal mode when prescaler >= 2*half+2: window start = mid-half, window end = mid+half.
  - Otherwise single-sample mode: sample once at Edge_Counter==mid and vote on that one sample.
- FSM states IDLE, COLLECT, DONE:
  - IDLE: when Data_Sample_EN=1 and Edge_Counter==start, capture rx_s (ones+=rx_s, idx=1). Go to COLLECT, or straight to the vote if the window has one sample.
  - COLLECT: on each cycle with Edge_Counter == start+idx, accumulate rx_s and idx++. Non-matching cycles are ignored. When idx reaches the window size, vote.
  - Vote (registered, same clock edge as the last capture is consumed): Sampled_bit <= (ones_total > window/2). Sampling_done=1 for exactly the next cycle. Go to DONE.
  - DONE: wait until Edge_Counter==0 or Data_Sample_EN=0, then go to IDLE with counters cleared.
- Latency: Sampled_bit and Sampling_done are valid 1 clock after the cycle where Edge_Counter==end (plus SYNC_STAGES relative to the RX_IN pin).
- Abort: Data_Sample_EN=0 or Edge_Counter==0 while in COLLECT causes:
  - return to IDLE, counters cleared;
  - no Sampling_done pulse;
  - Sampled_bit keeps its old value.
- Edge_Counter==0 in the same cycle as start==0 is a capture, not an abort.
- Only one done pulse per bit period, even if Edge_Counter revisits window values.
- Reset mid-COLLECT: all state returns to reset values immediately; no done pulse.

Optional Feature:
- Macro DATA_SAMPLING_NOISE_DET_EN.
- Defined: a zeros counter is kept alongside the ones counter. Noise_err pulses with Sampling_done whenever ones_total is neither 0 nor the window size. It is always 0 in single-sample mode.
- Undefined: Noise_err is tied to 0, and no extra counter logic is synthesised.

Test Plan:
- NUM_SAMPLES=3, SYNC_STAGES=0, prescaler=8, RX_IN=0 at Edge_Counter 3, 4, 5 -> samples at counts 3, 4, 5; Sampled_bit=0 and Sampling_done pulses exactly at count 6; Noise_err=0.
- NUM_SAMPLES=5, prescaler=16, rx_s pattern 1,0,1,1,0 over counts 6..10 -> Sampled_bit=1, single done pulse; Noise_err=1 with the macro defined, 0 without.
- NUM_SAMPLES=3, prescaler=2 -> single-sample mode, one capture at count 1; Sampled_bit equals rx_s at that count; Noise_err=0.
- prescaler=8, Data_Sample_EN dropped at count 4 after one capture -> no done pulse; Sampled_bit retains its prior value; next bit votes correctly from scratch.
- SYNC_STAGES=2, prescaler=8: RX_IN step to 0 aligned so rx_s=0 over counts 3..5 -> result 0, done at count 6.
- RST asserted low during COLLECT -> Sampled_bit=1, Sampling_done=0 asynchronously; after release, next bit is sampled normally.
